// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI initiator.
// Command encodings, frame/data widths, FSM state type and the frame builder.
package spi_pkg;

    localparam int unsigned CMD_W   = 2;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned FRAME_W = CMD_W + DATA_W;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned WAIT_W  = 4;
    localparam int unsigned CNT_W   = 3;

    localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
    localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        RECV,
        DONE
    } state_t;

    // Read-data frames carry a zero payload regardless of wr_data.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [CMD_W-1:0]  cmd,
        input logic [DATA_W-1:0] data
    );
        return {cmd, (cmd == CMD_RD_DATA) ? DATA_W'(0) : data};
    endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// spi_master_shifter: 10-bit parallel-load TX shift register (MSB first onto
// mosi) and RX shift register with bit counter (MSB first from miso).
// Ports: load_i/frame_i load a frame, shift_i advances TX, rx_en_i samples
// miso_i; mosi_o is the TX MSB; rx_next_c is the byte including the current
// miso bit; rx_last_c flags the 8th RX bit.
module spi_master_shifter
    import spi_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic               shift_i,
    input  logic               rx_en_i,
    input  logic               miso_i,
    output logic               mosi_o,
    output logic [DATA_W-1:0]  rx_next_c,
    output logic               rx_last_c
);

    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [DATA_W-2:0]  rx_q, rx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Zero fill means mosi returns to 0 once all frame bits have left.
    always_comb begin
        tx_d  = tx_q;
        rx_d  = rx_q;
        cnt_d = cnt_q;
        if (load_i) begin
            tx_d  = frame_i;
            cnt_d = '0;
        end else if (shift_i) begin
            tx_d = {tx_q[FRAME_W-2:0], 1'b0};
        end
        if (rx_en_i) begin
            rx_d  = rx_next_c[DATA_W-2:0];
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q  <= '0;
            rx_q  <= '0;
            cnt_q <= '0;
        end else begin
            tx_q  <= tx_d;
            rx_q  <= rx_d;
            cnt_q <= cnt_d;
        end
    end

    assign mosi_o    = tx_q[FRAME_W-1];
    assign rx_next_c = {rx_q, miso_i};
    assign rx_last_c = (cnt_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/spi_master.sv
// spi_master: SPI initiator sending 10-bit {cmd, payload} frames and, for
// read-data commands, capturing an 8-bit reply after RD_WAIT idle cycles.
// Ports: start/cmd/wr_data host request, ready/done handshake, rd_data and
// rd_valid read result, ss_n/mosi/miso serial pins. All outputs are flops.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned RD_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CMD_W-1:0]  cmd,
    input  logic [DATA_W-1:0] wr_data,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              ss_n,
    output logic              mosi,
    input  logic              miso
);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                rd_q, rd_d;
    logic                ss_n_q, ss_n_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    logic                load_c, shift_c, rx_en_c, rx_last_c;
    logic [DATA_W-1:0]   rx_next_c;
    logic [FRAME_W-1:0]  frame_c;

    spi_master_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load_c),
        .frame_i   (frame_c),
        .shift_i   (shift_c),
        .rx_en_i   (rx_en_c),
        .miso_i    (miso),
        .mosi_o    (mosi),
        .rx_next_c (rx_next_c),
        .rx_last_c (rx_last_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wait_d    = wait_q;
        rd_d      = rd_q;
        rd_data_d = rd_data_q;
        load_c    = 1'b0;
        shift_c   = 1'b0;
        rx_en_c   = 1'b0;
        frame_c   = build_frame(cmd, wr_data);

        case (state_q)
            // DONE behaves like IDLE for acceptance to allow back-to-back frames.
            IDLE, DONE: begin
                state_d = IDLE;
                if (start && ready_q) begin
                    state_d = SEND;
                    idx_d   = IDX_W'(FRAME_W - 1);
                    rd_d    = (cmd == CMD_RD_DATA);
                    load_c  = 1'b1;
                end
            end
            SEND: begin
                shift_c = 1'b1;
                if (idx_q == '0) begin
                    if (rd_q) begin
                        state_d = WAIT;
                        wait_d  = WAIT_W'(RD_WAIT - 1);
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            WAIT: begin
                if (wait_q == '0) begin
                    state_d = RECV;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            RECV: begin
                rx_en_c = 1'b1;
                if (rx_last_c) begin
                    state_d   = DONE;
                    rd_data_d = rx_next_c;
                end
            end
            default: state_d = IDLE;
        endcase

        ss_n_d     = !(state_d inside {SEND, WAIT, RECV});
        ready_d    = (state_d == IDLE) || (state_d == DONE);
        done_d     = (state_d == DONE);
        rd_valid_d = (state_q == RECV) && rx_last_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            wait_q     <= '0;
            rd_q       <= 1'b0;
            ss_n_q     <= 1'b1;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wait_q     <= wait_d;
            rd_q       <= rd_d;
            ss_n_q     <= ss_n_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign ss_n     = ss_n_q;
    assign ready    = ready_q;
    assign done     = done_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule
